// File: rtl/key_char_fifo.sv
// PS/2 make-event to character-code filter feeding a first-word-fall-through FIFO.
// Typematic repeats, releases and non-typing keys never reach the FIFO.
module key_char_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          flush,
    input  logic          key_valid,
    input  logic [7:0]    last_change,
    input  logic [127:0]  key_down,
    input  logic          char_ready,
    output logic          char_valid,
    output logic [4:0]    char_code,
    output logic [AW:0]   fill,
    output logic          overflow,
    output logic [9:0]    char_count
);

    localparam logic [AW:0] DEPTH_P   = (AW+1)'(DEPTH);
    localparam logic [9:0]  COUNT_MAX = 10'd1023;

    function automatic logic [4:0] decode_scan(input logic [7:0] sc);
        logic [4:0] code;
        case (sc)
            8'h1C: code = 5'd1;
            8'h32: code = 5'd2;
            8'h21: code = 5'd3;
            8'h23: code = 5'd4;
            8'h24: code = 5'd5;
            8'h2B: code = 5'd6;
            8'h34: code = 5'd7;
            8'h33: code = 5'd8;
            8'h43: code = 5'd9;
            8'h3B: code = 5'd10;
            8'h42: code = 5'd11;
            8'h4B: code = 5'd12;
            8'h3A: code = 5'd13;
            8'h31: code = 5'd14;
            8'h44: code = 5'd15;
            8'h4D: code = 5'd16;
            8'h15: code = 5'd17;
            8'h2D: code = 5'd18;
            8'h1B: code = 5'd19;
            8'h2C: code = 5'd20;
            8'h3C: code = 5'd21;
            8'h2A: code = 5'd22;
            8'h1D: code = 5'd23;
            8'h22: code = 5'd24;
            8'h35: code = 5'd25;
            8'h1A: code = 5'd26;
            8'h29: code = 5'd27;
            8'h66: code = 5'd28;
            default: code = 5'd0;
        endcase
        return code;
    endfunction

    logic [4:0]  mem [DEPTH];
    logic [AW:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0] wr_ptr_next, rd_ptr_next;
    logic [4:0]  held_code_reg;
    logic [4:0]  char_code_reg;
    logic        char_valid_reg;
    logic        overflow_reg;
    logic [9:0]  char_count_reg;

    logic [4:0]  dec_code;
    logic        is_make, press, release_ev, is_repeat, track_press;
    logic        push, pop, wr_en, empty, full;
    logic [AW:0] occupancy;
    logic [4:0]  head_next;

    always_comb begin
        dec_code    = decode_scan(last_change);
        is_make     = key_valid & ~last_change[7];
        press       = is_make & key_down[last_change[6:0]];
        release_ev  = is_make & ~key_down[last_change[6:0]];
        is_repeat   = press && (dec_code != 5'd0) && (dec_code == held_code_reg);
        track_press = press && (dec_code != 5'd0) && !is_repeat;
        push        = track_press && enable;

        occupancy   = wr_ptr_reg - rd_ptr_reg;
        empty       = (occupancy == '0);
        full        = (occupancy == DEPTH_P);
        pop         = !empty && char_ready;
        // A full FIFO still takes a push when the head leaves in the same cycle.
        wr_en       = push && (!full || pop);

        wr_ptr_next = wr_ptr_reg + {{AW{1'b0}}, wr_en};
        rd_ptr_next = rd_ptr_reg + {{AW{1'b0}}, pop};

        // Bypass the array when the entry being written becomes the new head.
        if (wr_en && (wr_ptr_reg == rd_ptr_next))
            head_next = dec_code;
        else
            head_next = mem[rd_ptr_next[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush && wr_en)
            mem[wr_ptr_reg[AW-1:0]] <= dec_code;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            held_code_reg  <= 5'd0;
            char_code_reg  <= 5'd0;
            char_valid_reg <= 1'b0;
            overflow_reg   <= 1'b0;
            char_count_reg <= 10'd0;
        end else begin
            wr_ptr_reg     <= wr_ptr_next;
            rd_ptr_reg     <= rd_ptr_next;
            char_valid_reg <= (wr_ptr_next != rd_ptr_next);
            char_code_reg  <= (wr_ptr_next != rd_ptr_next) ? head_next : 5'd0;

            if (push && full && !pop)
                overflow_reg <= 1'b1;

            if (wr_en && (char_count_reg != COUNT_MAX))
                char_count_reg <= char_count_reg + 10'd1;

            // Held-key tracking runs even while pushes are disabled.
            if (track_press)
                held_code_reg <= dec_code;
            else if (release_ev && (dec_code != 5'd0) && (dec_code == held_code_reg))
                held_code_reg <= 5'd0;
        end
    end

    assign char_valid = char_valid_reg;
    assign char_code  = char_code_reg;
    assign fill       = wr_ptr_reg - rd_ptr_reg;
    assign overflow   = overflow_reg;
    assign char_count = char_count_reg;

endmodule

// File: tb/tb_key_char_fifo.sv
// Directed bench for key_char_fifo: a queue-based reference model checked every cycle,
// plus literal expectations at each scenario step.
module tb_key_char_fifo;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          rst, enable, flush, key_valid, char_ready;
    logic [7:0]    last_change;
    logic [127:0]  key_down;
    logic          char_valid, overflow;
    logic [4:0]    char_code;
    logic [AW:0]   fill;
    logic [9:0]    char_count;

    int checks = 0;
    int errors = 0;

    key_char_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .enable(enable), .flush(flush),
        .key_valid(key_valid), .last_change(last_change), .key_down(key_down),
        .char_ready(char_ready), .char_valid(char_valid), .char_code(char_code),
        .fill(fill), .overflow(overflow), .char_count(char_count)
    );

    always #5 clk = ~clk;

    // Set-2 scan codes for A..Z; the letter's code is its position plus one.
    byte unsigned scan_tab [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                                    8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                                    8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                                    8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};

    function automatic int ref_decode(input logic [7:0] sc);
        for (int i = 0; i < 26; i++)
            if (scan_tab[i] == sc) return i + 1;
        if (sc == 8'h29) return 27;
        if (sc == 8'h66) return 28;
        return 0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model
    int  mq[$];
    int  m_held, m_cnt;
    bit  m_ovf, m_live = 1'b0;

    always @(posedge clk) begin
        int  d;
        bit  mk, pr, rl, rep, pp, ps;
        if (rst || flush) begin
            mq.delete();
            m_held = 0; m_cnt = 0; m_ovf = 1'b0; m_live = 1'b1;
        end else if (m_live) begin
            d   = ref_decode(last_change);
            mk  = key_valid && !last_change[7];
            pr  = mk && key_down[last_change[6:0]];
            rl  = mk && !key_down[last_change[6:0]];
            rep = pr && d != 0 && d == m_held;
            pp  = mq.size() > 0 && char_ready;
            ps  = pr && d != 0 && !rep && enable;
            if (pp) begin
                $display("pop  code=%0d", mq[0]);
                void'(mq.pop_front());
            end
            if (ps) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back(d);
                    if (m_cnt < 1023) m_cnt++;
                    $display("push code=%0d", d);
                end else begin
                    m_ovf = 1'b1;
                    $display("drop code=%0d (full)", d);
                end
            end
            if (pr && d != 0 && !rep) m_held = d;
            else if (rl && d != 0 && d == m_held) m_held = 0;
        end
    end

    always @(posedge clk) begin
        #1;
        if (m_live) begin
            check("char_valid", int'(char_valid), (mq.size() > 0) ? 1 : 0);
            check("char_code",  int'(char_code),  (mq.size() > 0) ? mq[0] : 0);
            check("fill",       int'(fill),       mq.size());
            check("overflow",   int'(overflow),   int'(m_ovf));
            check("char_count", int'(char_count), m_cnt);
        end
    end

    task automatic key_event(input logic [7:0] sc, input bit down);
        @(negedge clk);
        key_valid = 1'b1;
        last_change = sc;
        key_down[sc[6:0]] = down;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic press_release(input logic [7:0] sc);
        key_event(sc, 1'b1);
        key_event(sc, 1'b0);
    endtask

    task automatic pop_expect(input int exp);
        @(negedge clk);
        check("head_code", int'(char_code), exp);
        char_ready = 1'b1;
        @(negedge clk);
        char_ready = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"},    int'(char_valid), 0);
        check({tag, "_code"},     int'(char_code),  0);
        check({tag, "_fill"},     int'(fill),       0);
        check({tag, "_overflow"}, int'(overflow),   0);
        check({tag, "_count"},    int'(char_count), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; enable = 1'b1; flush = 1'b0; key_valid = 1'b0;
        char_ready = 1'b0; last_change = 8'h00; key_down = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_all_zero("reset");

        // 1: A, B, C queue up, then drain in order
        press_release(8'h1C); check("t1_fill1", int'(fill), 1);
        press_release(8'h32); check("t1_fill2", int'(fill), 2);
        press_release(8'h21); check("t1_fill3", int'(fill), 3);
        pop_expect(1); pop_expect(2); pop_expect(3);
        check("t1_fill_end", int'(fill), 0);

        // 2: typematic repeats of A are dropped until a release
        key_event(8'h1C, 1'b1);
        repeat (5) key_event(8'h1C, 1'b1);
        check("t2_fill_rep", int'(fill), 1);
        check("t2_count_rep", int'(char_count), 4);
        key_event(8'h1C, 1'b0);
        key_event(8'h1C, 1'b1);
        check("t2_fill_again", int'(fill), 2);
        key_event(8'h1C, 1'b0);
        pop_expect(1); pop_expect(1);

        // 3: nine keys into eight slots
        for (int i = 3; i < 12; i++) press_release(scan_tab[i]);
        check("t3_fill", int'(fill), 8);
        check("t3_overflow", int'(overflow), 1);
        check("t3_count", int'(char_count), 13);
        for (int i = 4; i < 12; i++) pop_expect(i);
        check("t3_fill_end", int'(fill), 0);
        check("t3_ovf_sticky", int'(overflow), 1);

        // 4: push and pop together while full
        for (int i = 0; i < 8; i++) press_release(scan_tab[i]);
        check("t4_fill_full", int'(fill), 8);
        @(negedge clk);
        key_valid = 1'b1; last_change = 8'h1A; key_down[8'h1A] = 1'b1; char_ready = 1'b1;
        @(negedge clk);
        key_valid = 1'b0; char_ready = 1'b0;
        check("t4_fill_stay", int'(fill), 8);
        key_event(8'h1A, 1'b0);
        for (int i = 2; i <= 8; i++) pop_expect(i);
        pop_expect(26);

        // 5: enable gating, backspace, extended codes, held key across enable
        enable = 1'b0;
        press_release(8'h29);
        check("t5_no_push", int'(fill), 0);
        enable = 1'b1;
        press_release(8'h66);
        check("t5_bs_fill", int'(fill), 1);
        check("t5_bs_code", int'(char_code), 28);
        pop_expect(28);
        key_event(8'h9C, 1'b1);
        check("t5_ext_ignored", int'(fill), 0);
        key_event(8'h9C, 1'b0);
        enable = 1'b0;
        key_event(8'h1C, 1'b1);
        enable = 1'b1;
        key_event(8'h1C, 1'b1);
        check("t5_held_no_emit", int'(fill), 0);
        key_event(8'h1C, 1'b0);

        // 6: flush and reset mid-stream with a concurrent key
        for (int i = 0; i < 5; i++) press_release(scan_tab[i]);
        check("t6_fill5", int'(fill), 5);
        @(negedge clk);
        flush = 1'b1; key_valid = 1'b1; last_change = 8'h2C; key_down[8'h2C] = 1'b1;
        char_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0; key_valid = 1'b0; char_ready = 1'b0;
        check_all_zero("flush");
        key_event(8'h2C, 1'b0);
        key_event(8'h1C, 1'b1);
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        key_event(8'h1C, 1'b1);
        check("t6_held_cleared", int'(fill), 1);
        key_event(8'h1C, 1'b0);
        for (int i = 0; i < 4; i++) press_release(scan_tab[i + 10]);
        check("t6_fill5b", int'(fill), 5);
        @(negedge clk);
        rst = 1'b1; key_valid = 1'b1; last_change = 8'h2C; key_down[8'h2C] = 1'b1;
        @(negedge clk);
        rst = 1'b0; key_valid = 1'b0;
        check_all_zero("rst");
        key_event(8'h2C, 1'b0);
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
